// File: rtl/systolic_array_8x8_pkg.sv
// Shared constants and arithmetic helpers for the 8x8 output-stationary systolic array.
// Saturation helper is only referenced when SYSTOLIC_SAT_EN is defined.
package systolic_pkg;

  localparam int unsigned ARRAY_N        = 8;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ACC_WIDTH  = 32;

  // Exact 64-bit sum clamped to the signed range of a width-bit accumulator (width <= 63).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                 input logic signed [63:0] y,
                                                 input int unsigned        width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = x + y;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/systolic_array_8x8_pe.sv
// Systolic processing element: MAC into a stationary accumulator, forward a right and b down.
// Build option SYSTOLIC_SAT_EN selects saturating instead of wrap-around accumulation.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    acc_next;

  assign prod     = a_in * b_in;
  assign prod_ext = ACC_WIDTH'(prod);

`ifdef SYSTOLIC_SAT_EN
  assign acc_next = ACC_WIDTH'(sat_add(64'(acc), 64'(prod_ext), ACC_WIDTH));
`else
  assign acc_next = acc + prod_ext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      acc   <= acc_next;
      a_out <= a_in;
      b_out <= b_in;
    end
  end

endmodule

// File: rtl/systolic_array_8x8.sv
// 8x8 output-stationary systolic matrix multiplier; feeder supplies pre-skewed A rows and B columns.
// Build option SYSTOLIC_SAT_EN (see systolic_pe) enables saturating accumulators.
module systolic_array_8x8
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] A_in  [0:ARRAY_N-1],
  input  logic signed [DATA_WIDTH-1:0] B_in  [0:ARRAY_N-1],
  output logic signed [ACC_WIDTH-1:0]  C_out [0:ARRAY_N-1][0:ARRAY_N-1]
);

  logic signed [DATA_WIDTH-1:0] a_src [0:ARRAY_N-1][0:ARRAY_N-1];
  logic signed [DATA_WIDTH-1:0] b_src [0:ARRAY_N-1][0:ARRAY_N-1];
  logic signed [DATA_WIDTH-1:0] a_reg [0:ARRAY_N-1][0:ARRAY_N-1];
  logic signed [DATA_WIDTH-1:0] b_reg [0:ARRAY_N-1][0:ARRAY_N-1];

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_row
    for (genvar j = 0; j < ARRAY_N; j++) begin : g_col
      // Edge PEs take the unregistered array inputs; interior PEs take the neighbour's register.
      if (j == 0) begin : g_a_edge
        assign a_src[i][j] = A_in[i];
      end else begin : g_a_link
        assign a_src[i][j] = a_reg[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_src[i][j] = B_in[j];
      end else begin : g_b_link
        assign b_src[i][j] = b_reg[i-1][j];
      end

      systolic_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .a_in  (a_src[i][j]),
        .b_in  (b_src[i][j]),
        .a_out (a_reg[i][j]),
        .b_out (b_reg[i][j]),
        .acc   (C_out[i][j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_array_8x8.sv
// Directed self-checking bench for systolic_array_8x8; honours SYSTOLIC_SAT_EN for overflow expectations.
module tb_systolic_array_8x8;

  localparam int N = 8;

  typedef struct {
    int                 tcase;
    int                 step;
    int                 row;
    int                 col;
    logic signed [31:0] exp;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] A_in  [0:N-1];
  logic signed [15:0] B_in  [0:N-1];
  logic signed [31:0] C_out [0:N-1][0:N-1];

  int   errors = 0;
  int   checks = 0;
  int   ma [0:N-1][0:N-1];
  int   mb [0:N-1][0:N-1];
  vec_t vecs[$];
  logic signed [31:0] ov_one;
  logic signed [31:0] ov_final;

  systolic_array_8x8 #(
    .DATA_WIDTH (16),
    .ACC_WIDTH  (32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .A_in  (A_in),
    .B_in  (B_in),
    .C_out (C_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    for (int i = 0; i < N; i++) begin
      A_in[i] = '0;
      B_in[i] = '0;
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s C[%0d][%0d]", name, i, j), C_out[i][j], 32'sd0);
  endtask

  task automatic drive_skew(input int t);
    for (int i = 0; i < N; i++) begin
      A_in[i] = '0;
      B_in[i] = '0;
      if (t - i >= 0 && t - i <= 7) begin
        A_in[i] = 16'(ma[i][t-i]);
        B_in[i] = 16'(mb[t-i][i]);
      end
    end
  endtask

  task automatic check_table(input int tc, input int t);
    foreach (vecs[n])
      if (vecs[n].tcase == tc && vecs[n].step == t)
        chk($sformatf("tc%0d edge%0d C[%0d][%0d]", tc, t, vecs[n].row, vecs[n].col),
            C_out[vecs[n].row][vecs[n].col], vecs[n].exp);
  endtask

  task automatic check_full(input int tc, input int t);
    int r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (tc == 2) begin
          chk($sformatf("tc%0d full edge%0d C[%0d][%0d]", tc, t, i, j), C_out[i][j], ov_final);
        end else begin
          r = 0;
          for (int k = 0; k < N; k++) r += ma[i][k] * mb[k][j];
          chk($sformatf("tc%0d full edge%0d C[%0d][%0d]", tc, t, i, j), C_out[i][j], 32'(r));
        end
      end
  endtask

  task automatic do_reset();
    zero_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_load(input int tc, input int last_edge);
    for (int t = 0; t <= last_edge; t++) begin
      drive_skew(t);
      @(posedge clk);
      #1;
      check_table(tc, t);
      if (t == 21 || t == 31) check_full(tc, t);
    end
    zero_inputs();
  endtask

  task automatic set_ramp();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 8 * i + j + 1;
        mb[i][j] = 64 - (8 * i + j);
      end
  endtask

  initial begin
`ifdef SYSTOLIC_SAT_EN
    ov_one   = 32'sh7FFF_FFFF;
    ov_final = 32'sh7FFF_FFFF;
`else
    ov_one   = 32'sh8000_0000;
    ov_final = 32'sh0000_0000;
`endif
    // tcase 0: ramp, 1: identity, 2: overflow, 3: ramp reload after mid-run reset
    vecs.push_back('{0,  7, 0, 0, 32'sd960});
    vecs.push_back('{0, 20, 7, 7, 32'sd13636});
    vecs.push_back('{0, 21, 7, 7, 32'sd13700});
    vecs.push_back('{0, 21, 0, 0, 32'sd960});
    vecs.push_back('{0, 21, 0, 7, 32'sd708});
    vecs.push_back('{0, 21, 7, 0, 32'sd17088});
    vecs.push_back('{0, 31, 7, 7, 32'sd13700});
    vecs.push_back('{1, 21, 0, 0, -32'sd32});
    vecs.push_back('{1, 21, 7, 7, 32'sd31});
    vecs.push_back('{1, 21, 3, 5, -32'sd3});
    vecs.push_back('{1, 21, 4, 0, 32'sd0});
    vecs.push_back('{2,  1, 0, 0, ov_one});
    vecs.push_back('{2, 21, 7, 7, ov_final});
    vecs.push_back('{3, 20, 7, 7, 32'sd13636});
    vecs.push_back('{3, 21, 7, 7, 32'sd13700});

    // Reset held with nonzero inputs, then a long idle stretch.
    for (int i = 0; i < N; i++) begin
      A_in[i] = 16'(i + 1);
      B_in[i] = 16'(i + 3);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    zero_inputs();
    repeat (30) @(posedge clk);
    #1;
    check_all_zero("idle");

    set_ramp();
    do_reset();
    run_load(0, 31);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = 8 * i + j - 32;
      end
    do_reset();
    run_load(1, 31);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = -32768;
        mb[i][j] = -32768;
      end
    do_reset();
    run_load(2, 21);

    // Mid-run reset: asynchronous assert between edges after edge 10.
    set_ramp();
    do_reset();
    for (int t = 0; t <= 10; t++) begin
      drive_skew(t);
      @(posedge clk);
      #1;
    end
    chk("midrun pre-reset C[0][0]", C_out[0][0], 32'sd960);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrun async");
    @(posedge clk);
    #1;
    chk("midrun held C[7][7]", C_out[7][7], 32'sd0);
    rst = 1'b0;
    zero_inputs();
    run_load(3, 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
